// File: rtl/badpoint_lut_write_scheduler.sv
// Single write-port scheduler for the bad-pixel LUT: host/detector round-robin, sorted auto append, clear.
// Optional double-buffered LUT banks when LUT_DBUF_EN is defined.
module badpoint_lut_write_scheduler #(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 10,
    parameter int BAD_POINT_NUM = 128,
    parameter int BAD_POINT_BIT = 7,
`ifdef LUT_DBUF_EN
    localparam int ADDR_W = BAD_POINT_BIT + 1
`else
    localparam int ADDR_W = BAD_POINT_BIT
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     auto_en,
    input  logic [BAD_POINT_BIT:0]   host_num,
    input  logic                     clear_req,
    output logic                     clear_busy,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [BAD_POINT_BIT-1:0] host_addr,
    input  logic [31:0]              host_data,
    input  logic                     det_valid,
    output logic                     det_ready,
    input  logic [WIDTH_BITS-1:0]    det_x,
    input  logic [HEIGHT_BITS-1:0]   det_y,
    output logic                     wen_lut,
    output logic [ADDR_W-1:0]        waddr_lut,
    output logic [31:0]              wdata_lut,
    output logic [BAD_POINT_BIT:0]   bad_point_num,
    output logic                     rd_bank,
    output logic                     overflow
);

    localparam int KEY_W = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [BAD_POINT_BIT:0]   PTR_FULL = (BAD_POINT_BIT + 1)'(BAD_POINT_NUM);
    localparam logic [BAD_POINT_BIT:0]   PTR_ONE  = (BAD_POINT_BIT + 1)'(1);
    localparam logic [BAD_POINT_BIT-1:0] CLR_LAST = BAD_POINT_BIT'(BAD_POINT_NUM - 1);
    localparam logic [BAD_POINT_BIT-1:0] CLR_ONE  = BAD_POINT_BIT'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;

    state_t                   state_q, state_d;
    logic [BAD_POINT_BIT:0]   ptr_q, ptr_d, ptr_base;
    logic [KEY_W-1:0]         key_q, key_d, key_in;
    logic                     key_vld_q, key_vld_d, key_vld_base;
    logic                     ovf_q, ovf_d;
    logic [BAD_POINT_BIT-1:0] clr_cnt_q, clr_cnt_d;
    logic                     last_det_q, last_det_d;
    logic                     wen_q, wen_d;
    logic [ADDR_W-1:0]        waddr_q, waddr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [BAD_POINT_BIT:0]   bpn_q, bpn_d;
    logic [ADDR_W-1:0]        bank_base;
    logic                     gnt_host, gnt_det;

`ifdef LUT_DBUF_EN
    // Writes always go to the bank the checker is not reading, including a beat that coincides with frame_start.
    logic rd_bank_q, rd_bank_d;
    assign rd_bank_d = rd_bank_q ^ frame_start;
    always_ff @(posedge clk) begin
        if (rst) rd_bank_q <= 1'b0;
        else     rd_bank_q <= rd_bank_d;
    end
    assign rd_bank   = rd_bank_q;
    assign bank_base = {~rd_bank_d, {BAD_POINT_BIT{1'b0}}};
`else
    assign rd_bank   = 1'b0;
    assign bank_base = '0;
`endif

    // A frame_start in the same cycle as a detector beat opens the new frame first.
    assign ptr_base     = frame_start ? '0 : ptr_q;
    assign key_vld_base = frame_start ? 1'b0 : key_vld_q;
    assign key_in       = {det_y, det_x};

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        ptr_d      = ptr_base;
        key_d      = key_q;
        key_vld_d  = key_vld_base;
        ovf_d      = ovf_q;
        clr_cnt_d  = clr_cnt_q;
        last_det_d = last_det_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        bpn_d      = bpn_q;
        gnt_host   = 1'b0;
        gnt_det    = 1'b0;

        if (frame_start)
            bpn_d = (state_q == S_CLEAR) ? '0 : (auto_en ? ptr_q : host_num);

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (clear_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    ptr_d     = '0;
                    key_vld_d = 1'b0;
                    ovf_d     = 1'b0;
                end else if (state_q == S_IDLE) begin
                    state_d = S_RUN;
                end else begin
                    gnt_host = host_valid && (!det_valid || last_det_q);
                    gnt_det  = det_valid && !gnt_host;
                    if (gnt_host) begin
                        last_det_d = 1'b0;
                        wen_d      = 1'b1;
                        waddr_d    = bank_base | ADDR_W'(host_addr);
                        wdata_d    = host_data;
                    end
                    if (gnt_det) begin
                        last_det_d = 1'b1;
                        if (!key_vld_base || key_in > key_q) begin
                            if (ptr_base == PTR_FULL) begin
                                ovf_d = 1'b1;
                            end else begin
                                wen_d     = 1'b1;
                                waddr_d   = bank_base | ADDR_W'(ptr_base[BAD_POINT_BIT-1:0]);
                                wdata_d   = {16'(det_y), 16'(det_x)};
                                ptr_d     = ptr_base + PTR_ONE;
                                key_d     = key_in;
                                key_vld_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_CLEAR: begin
                wen_d     = 1'b1;
                waddr_d   = bank_base | ADDR_W'(clr_cnt_q);
                wdata_d   = 32'hFFFF_FFFF;
                clr_cnt_d = clr_cnt_q + CLR_ONE;
                if (clr_cnt_q == CLR_LAST) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            key_q      <= '0;
            key_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
            clr_cnt_q  <= '0;
            last_det_q <= 1'b1;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            bpn_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            key_q      <= key_d;
            key_vld_q  <= key_vld_d;
            ovf_q      <= ovf_d;
            clr_cnt_q  <= clr_cnt_d;
            last_det_q <= last_det_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            bpn_q      <= bpn_d;
        end
    end

    assign clear_busy    = (state_q == S_CLEAR);
    assign host_ready    = gnt_host;
    assign det_ready     = gnt_det;
    assign wen_lut       = wen_q;
    assign waddr_lut     = waddr_q;
    assign wdata_lut     = wdata_q;
    assign bad_point_num = bpn_q;
    assign overflow      = ovf_q;

endmodule
